// File: rtl/pot_scan_core.sv
// ============================================================================
// Module      : pot_scan_core
// Description : POKEY paddle scanner. Counts scan ticks per pot line from
//               capacitor release until threshold crossing or terminal count.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pot_scan_core #(
  parameter int POT_MAX    = 228,
  parameter int DUMP_TICKS = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       enp,
  input  logic       en15,
  input  logic       potgo,
  input  logic       fast_scan,
  input  logic [7:0] pot_in,
  output logic       pot_dump,
  output logic [7:0] pot0,
  output logic [7:0] pot1,
  output logic [7:0] pot2,
  output logic [7:0] pot3,
  output logic [7:0] pot4,
  output logic [7:0] pot5,
  output logic [7:0] pot6,
  output logic [7:0] pot7,
  output logic [7:0] allpot
);

  localparam int              c_DW        = (DUMP_TICKS > 1) ? $clog2(DUMP_TICKS) : 1;
  localparam logic [c_DW-1:0] c_DUMP_LAST = c_DW'(DUMP_TICKS - 1);
  localparam logic [7:0]      c_POT_MAX   = 8'(POT_MAX);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_DUMP = 2'd1;
  localparam logic [1:0] c_SCAN = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [7:0]      r_pin_meta;
  logic [7:0]      r_pin_s;
  logic [7:0]      r_counter;
  logic [c_DW-1:0] r_dump_cnt;
  logic [7:0]      r_allpot;
  logic [63:0]     w_pots;

  logic       w_go;
  logic       w_tick;
  logic       w_dump_tick;
  logic       w_dump_done;
  logic       w_scan_tick;
  logic [7:0] w_cnt_inc;
  logic       w_term;
  logic [7:0] w_allpot_nxt;

  // potgo outranks any coincident tick, so every tick qualifier masks it out
  assign w_go         = enp & potgo;
  assign w_tick       = enp & (fast_scan | en15);
  assign w_dump_tick  = w_tick & ~w_go & (r_state == c_DUMP);
  assign w_dump_done  = w_dump_tick & (r_dump_cnt == c_DUMP_LAST);
  assign w_scan_tick  = w_tick & ~w_go & (r_state == c_SCAN);
  assign w_cnt_inc    = r_counter + 8'd1;
  assign w_term       = (w_cnt_inc == c_POT_MAX);
  assign w_allpot_nxt = w_term ? 8'h00 : (r_allpot & ~r_pin_s);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_pin_meta <= 8'h00;
      r_pin_s    <= 8'h00;
    end else begin
      r_pin_meta <= pot_in;
      r_pin_s    <= r_pin_meta;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_go) begin
      w_state_nxt = c_DUMP;
    end else begin
      case (r_state)
        c_DUMP: if (w_dump_done) w_state_nxt = c_SCAN;
        c_SCAN: if (w_scan_tick && (w_allpot_nxt == 8'h00)) w_state_nxt = c_IDLE;
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  always_comb begin
    pot_dump = (r_state != c_SCAN);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_counter  <= 8'h00;
      r_dump_cnt <= '0;
      r_allpot   <= 8'h00;
    end else if (w_go) begin
      r_counter  <= 8'h00;
      r_dump_cnt <= '0;
      r_allpot   <= 8'hFF;
    end else begin
      if (w_dump_tick) begin
        if (w_dump_done) begin
          r_dump_cnt <= '0;
          r_counter  <= 8'h00;
        end else begin
          r_dump_cnt <= r_dump_cnt + c_DW'(1);
        end
      end
      if (w_scan_tick) begin
        r_counter <= w_cnt_inc;
        r_allpot  <= w_allpot_nxt;
      end
    end
  end

  // Lines still scanning and below threshold take the new count; on the
  // terminal tick that count is POT_MAX, which also latches the stragglers.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pot
    logic [7:0] r_pot;
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        r_pot <= 8'h00;
      end else if (w_go) begin
        r_pot <= 8'h00;
      end else if (w_scan_tick && r_allpot[gi] && !r_pin_s[gi]) begin
        r_pot <= w_cnt_inc;
      end
    end
    assign w_pots[gi*8 +: 8] = r_pot;
  end

  assign pot0   = w_pots[7:0];
  assign pot1   = w_pots[15:8];
  assign pot2   = w_pots[23:16];
  assign pot3   = w_pots[31:24];
  assign pot4   = w_pots[39:32];
  assign pot5   = w_pots[47:40];
  assign pot6   = w_pots[55:48];
  assign pot7   = w_pots[63:56];
  assign allpot = r_allpot;

endmodule

`default_nettype wire

// File: tb/tb_pot_scan_core.sv
// ============================================================================
// Module      : tb_pot_scan_core
// Description : Self-checking bench for pot_scan_core using per-line
//               threshold-crossing tick numbers as the reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pot_scan_core;

  localparam int c_POT_MAX = 228;
  localparam int c_DUMP    = 2;
  localparam int c_NEVER   = 999;

  logic        clk = 1'b0;
  logic        nreset;
  logic        enp;
  logic        en15;
  logic        potgo;
  logic        fast_scan;
  logic [7:0]  pot_in;
  logic        pot_dump;
  logic [7:0]  pot0, pot1, pot2, pot3, pot4, pot5, pot6, pot7;
  logic [7:0]  allpot;
  logic [63:0] pots;

  int n_chk  = 0;
  int n_pass = 0;
  int k[8];

  always #5 clk = ~clk;

  assign pots = {pot7, pot6, pot5, pot4, pot3, pot2, pot1, pot0};

  pot_scan_core #(.POT_MAX(c_POT_MAX), .DUMP_TICKS(c_DUMP)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .enp       (enp),
    .en15      (en15),
    .potgo     (potgo),
    .fast_scan (fast_scan),
    .pot_in    (pot_in),
    .pot_dump  (pot_dump),
    .pot0      (pot0),
    .pot1      (pot1),
    .pot2      (pot2),
    .pot3      (pot3),
    .pot4      (pot4),
    .pot5      (pot5),
    .pot6      (pot6),
    .pot7      (pot7),
    .allpot    (allpot)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic chk_state(input string tag, input logic [63:0] ep, input logic [7:0] ea,
                           input logic ed);
    chk({tag, ".pots"}, pots, ep);
    chk({tag, ".allpot"}, {56'd0, allpot}, {56'd0, ea});
    chk({tag, ".dump"}, {63'd0, pot_dump}, {63'd0, ed});
  endtask

  // Inputs change on the falling edge; the DUT samples on the rising edge.
  task automatic cyc(input logic e, input logic e15, input logic go);
    enp   = e;
    en15  = e15;
    potgo = go;
    @(posedge clk);
    @(negedge clk);
    enp   = 1'b0;
    en15  = 1'b0;
    potgo = 1'b0;
  endtask

  task automatic do_tick(input logic go);
    if (fast_scan) begin
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'($urandom_range(0, 1)), go);
    end else begin
      repeat (113) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, go);
    end
  endtask

  // A line is low until just before its crossing tick, then high, then don't-care.
  task automatic drive_pins(input int done);
    for (int i = 0; i < 8; i++) begin
      if (done < k[i] - 1)       pot_in[i] = 1'b0;
      else if (done == k[i] - 1) pot_in[i] = 1'b1;
      else                       pot_in[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_scan(input int abort_after);
    int t;
    logic [63:0] ep;
    logic [7:0]  ea;
    t  = 0;
    ep = '0;
    ea = '0;
    for (int i = 0; i < 8; i++) begin
      int m;
      m = (k[i] < c_POT_MAX) ? k[i] : c_POT_MAX;
      if (m > t) t = m;
    end
    drive_pins(0);
    do_tick(1'b1);
    chk_state("potgo", 64'd0, 8'hFF, 1'b1);
    for (int d = 1; d <= c_DUMP; d++) begin
      do_tick(1'b0);
      chk_state("dump", 64'd0, 8'hFF, d < c_DUMP);
    end
    for (int j = 1; j <= t; j++) begin
      if (abort_after > 0 && j > abort_after) return;
      do_tick(1'b0);
      for (int i = 0; i < 8; i++) begin
        ep[i*8 +: 8] = (k[i] <= j) ? 8'(k[i] - 1) : 8'(j);
        ea[i]        = (k[i] > j) && (j < c_POT_MAX);
      end
      chk_state("scan", ep, ea, j == t);
      drive_pins(j);
    end
    repeat (2) begin
      do_tick(1'b0);
      chk_state("hold", ep, 8'h00, 1'b1);
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 8; i++) k[i] = v;
  endtask

  initial begin
    nreset    = 1'b0;
    enp       = 1'b0;
    en15      = 1'b0;
    potgo     = 1'b0;
    fast_scan = 1'b1;
    pot_in    = 8'($urandom);
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    repeat (4) begin
      pot_in = 8'($urandom);
      do_tick(1'b0);
      chk_state("reset", 64'd0, 8'h00, 1'b1);
    end

    set_all(c_NEVER);
    run_scan(0);

    set_all(c_NEVER);
    k[3] = 51;
    k[0] = 1;
    run_scan(0);

    set_all(1);
    run_scan(0);

    set_all(c_NEVER);
    k[1] = c_POT_MAX;
    k[2] = c_POT_MAX - 1;
    k[4] = c_POT_MAX + 1;
    run_scan(0);

    // Restart: the next potgo lands on a live scan tick at count 100.
    set_all(c_NEVER);
    run_scan(100);
    for (int i = 0; i < 8; i++) k[i] = $urandom_range(1, 150);
    run_scan(0);

    set_all(c_NEVER);
    run_scan(100);
    nreset = 1'b0;
    #1;
    chk_state("async_rst", 64'd0, 8'h00, 1'b1);
    @(negedge clk);
    nreset = 1'b1;
    repeat (3) begin
      do_tick(1'b0);
      chk_state("post_rst", 64'd0, 8'h00, 1'b1);
    end

    repeat (5) begin
      for (int i = 0; i < 8; i++)
        k[i] = ($urandom_range(0, 3) == 0) ? c_NEVER : int'($urandom_range(1, 240));
      run_scan(0);
    end

    fast_scan = 1'b0;
    set_all(c_NEVER);
    k[6] = 40;
    run_scan(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
